// File: rtl/cpm_word_packer_if.sv
// Sample stream in, FIFO push interface out, bundled for the CPM word packer.
// The master modport is the upstream source and FIFO side; slave is the packer.
interface cpm_word_packer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int IN_WIDTH   = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_last;
  logic                  fifo_push;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_full;

  modport master (
    output in_valid, in_data, in_last, fifo_full,
    input  in_ready, fifo_push, fifo_data
  );

  modport slave (
    input  in_valid, in_data, in_last, fifo_full,
    output in_ready, fifo_push, fifo_data
  );
endinterface

// File: rtl/cpm_word_packer.sv
// Packs narrow samples little-endian into DATA_WIDTH words for the CPM FIFO,
// with frame-end flush/padding, a synchronous clear and pushed-word status.
module cpm_word_packer #(
  parameter int                  DATA_WIDTH = 64,
  parameter int                  IN_WIDTH   = 8,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                  WCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Reset,
  cpm_word_packer_if.slave      bus,
  output logic [WCNT_WIDTH-1:0] word_cnt,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int LANES  = DATA_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(LANES + 1);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] word;
  logic [LANE_W-1:0]     lane;
  logic                  hold_valid;
  logic                  hold_last;
  logic                  ready;
  logic                  push;
  logic                  accept;
  logic                  complete;

  assign ready    = !(hold_valid && bus.fifo_full) && !Reset;
  assign push     = hold_valid && !bus.fifo_full && !Reset;
  assign accept   = bus.in_valid && ready;
  assign complete = accept && ((lane == LANE_W'(LANES - 1)) || bus.in_last);

  assign bus.in_ready  = ready;
  assign bus.fifo_push = push;
  assign bus.fifo_data = hold;
  assign busy          = hold_valid || (lane != '0);

  // Word as it would look if the current sample closed it: lanes above are padded.
  always_comb begin
    word = acc;
    for (int i = 0; i < LANES; i++) begin
      if (LANE_W'(i) == lane) begin
        word[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end else if (LANE_W'(i) > lane) begin
        word[i*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
      end
    end
  end

  // A completion may reload hold on the same edge that pushes the old word out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      lane       <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
    end else if (Reset) begin
      acc        <= '0;
      lane       <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
    end else if (complete) begin
      hold       <= word;
      hold_valid <= 1'b1;
      hold_last  <= bus.in_last;
      acc        <= '0;
      lane       <= '0;
    end else begin
      if (push) begin
        hold_valid <= 1'b0;
      end
      if (accept) begin
        acc[lane*IN_WIDTH +: IN_WIDTH] <= bus.in_data;
        lane                           <= lane + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else if (Reset) begin
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= push && hold_last;
      if (push) begin
        word_cnt <= word_cnt + WCNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_cpm_word_packer.sv
// Directed and randomized bench for cpm_word_packer against a queue-based
// reference model of the packing, handshake and status rules.
module tb_cpm_word_packer;
  localparam int             DW    = 64;
  localparam int             IW    = 8;
  localparam int             LANES = DW / IW;
  localparam int             WW    = 16;
  localparam logic [IW-1:0]  PAD   = '0;

  logic          clk;
  logic          rst_n;
  logic          Reset;
  logic [WW-1:0] word_cnt;
  logic          frame_done;
  logic          busy;

  cpm_word_packer_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) bus ();

  cpm_word_packer #(
    .DATA_WIDTH(DW),
    .IN_WIDTH  (IW),
    .PAD_VALUE (PAD),
    .WCNT_WIDTH(WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Reset     (Reset),
    .bus       (bus),
    .word_cnt  (word_cnt),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_accepts;
  int dut_pushes;

  // Reference model: samples of the open word, plus the one-word hold slot.
  logic [IW-1:0] m_q[$];
  logic [DW-1:0] m_hold;
  logic          m_hv;
  logic          m_hl;
  logic          m_fd;
  logic [WW-1:0] m_wcnt;
  logic          m_accept;

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_word();
    logic [DW-1:0] w;
    logic [IW-1:0] v;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      v = (k < m_q.size()) ? m_q[k] : PAD;
      w = w | (DW'(v) << (IW * k));
    end
    return w;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_hold = '0;
    m_hv   = 1'b0;
    m_hl   = 1'b0;
    m_fd   = 1'b0;
    m_wcnt = '0;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [IW-1:0] data, input logic last, input logic full);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.fifo_full = full;
  endtask

  // Compare outputs mid-cycle, advance the model across the coming edge, return #1 after it.
  task automatic clock_cycle();
    logic rdy;
    logic push;
    @(negedge clk);
    rdy  = !(m_hv && bus.fifo_full) && !Reset;
    push = m_hv && !bus.fifo_full && !Reset;
    check_output("in_ready",   DW'(bus.in_ready),  DW'(rdy));
    check_output("fifo_push",  DW'(bus.fifo_push), DW'(push));
    check_output("fifo_data",  bus.fifo_data,      m_hold);
    check_output("word_cnt",   DW'(word_cnt),      DW'(m_wcnt));
    check_output("frame_done", DW'(frame_done),    DW'(m_fd));
    check_output("busy",       DW'(busy),          DW'(m_hv || (m_q.size() != 0)));
    if (bus.in_valid && bus.in_ready) dut_accepts++;
    if (bus.fifo_push) dut_pushes++;
    m_accept = 1'b0;
    if (Reset) begin
      m_reset();
    end else begin
      m_fd = push && m_hl;
      if (push) begin
        m_wcnt = m_wcnt + WW'(1);
        m_hv   = 1'b0;
      end
      if (bus.in_valid && rdy) begin
        m_accept = 1'b1;
        m_q.push_back(bus.in_data);
        if ((m_q.size() == LANES) || bus.in_last) begin
          m_hold = pack_word();
          m_hv   = 1'b1;
          m_hl   = bus.in_last;
          m_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    Reset = 1'b1;
    clock_cycle();
    Reset = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] bp[20];
    int idx;

    rst_n = 1'b0;
    Reset = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    m_reset();
    #3;
    check_output("rst_in_ready",  DW'(bus.in_ready),  DW'(1'b1));
    check_output("rst_fifo_push", DW'(bus.fifo_push), DW'(1'b0));
    check_output("rst_fifo_data", bus.fifo_data,      '0);
    check_output("rst_word_cnt",  DW'(word_cnt),      '0);
    check_output("rst_busy",      DW'(busy),          DW'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full word 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, IW'(i), 1'b0, 1'b0);
      clock_cycle();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("t1_push", DW'(bus.fifo_push), DW'(1'b1));
    check_output("t1_data", bus.fifo_data, 64'h0807060504030201);
    clock_cycle();
    check_output("t1_word_cnt",   DW'(word_cnt),   DW'(1));
    check_output("t1_frame_done", DW'(frame_done), DW'(1'b0));

    // Short frame with padding
    apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0); clock_cycle();
    apply_stimulus(1'b1, 8'hA2, 1'b0, 1'b0); clock_cycle();
    apply_stimulus(1'b1, 8'hA3, 1'b1, 1'b0); clock_cycle();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("t2_push", DW'(bus.fifo_push), DW'(1'b1));
    check_output("t2_data", bus.fifo_data, 64'h0000000000A3A2A1);
    clock_cycle();
    check_output("t2_frame_done", DW'(frame_done), DW'(1'b1));
    check_output("t2_busy",       DW'(busy),       DW'(1'b0));
    clock_cycle();
    check_output("t2_frame_done_end", DW'(frame_done), DW'(1'b0));

    // Streaming 24 random samples
    pulse_reset();
    dut_pushes = 0;
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(1'b1, IW'($urandom), 1'b0, 1'b0);
      clock_cycle();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    clock_cycle();
    clock_cycle();
    check_output("t3_word_cnt", DW'(word_cnt), DW'(3));
    check_output("t3_pushes",   DW'(dut_pushes), DW'(3));

    // Backpressure: 20 samples offered while the FIFO is full for 12 cycles
    pulse_reset();
    for (int i = 0; i < 20; i++) bp[i] = IW'($urandom);
    dut_accepts = 0;
    dut_pushes  = 0;
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      apply_stimulus(idx < 20, (idx < 20) ? bp[idx] : '0, idx == 19, 1'b1);
      clock_cycle();
      if (m_accept) idx++;
    end
    check_output("t4_accepts_full", DW'(dut_accepts), DW'(8));
    check_output("t4_pushes_full",  DW'(dut_pushes),  DW'(0));
    for (int cyc = 0; cyc < 28; cyc++) begin
      apply_stimulus(idx < 20, (idx < 20) ? bp[idx] : '0, idx == 19, 1'b0);
      clock_cycle();
      if (m_accept) idx++;
    end
    check_output("t4_accepts", DW'(dut_accepts), DW'(20));
    check_output("t4_pushes",  DW'(dut_pushes),  DW'(3));

    // Reset mid-word discards the partial word
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, IW'($urandom), 1'b0, 1'b0);
      clock_cycle();
    end
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, IW'($urandom), 1'b0, 1'b0);
      clock_cycle();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    clock_cycle();
    clock_cycle();
    check_output("t5_word_cnt", DW'(word_cnt), DW'(1));

    // Asynchronous reset while a word is held
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, IW'($urandom), 1'b0, 1'b1);
      clock_cycle();
    end
    check_output("t6_busy_before", DW'(busy), DW'(1'b1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("t6_fifo_push", DW'(bus.fifo_push), DW'(1'b0));
    check_output("t6_word_cnt",  DW'(word_cnt),      '0);
    check_output("t6_in_ready",  DW'(bus.in_ready),  DW'(1'b1));
    check_output("t6_busy",      DW'(busy),          DW'(1'b0));
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic with occasional backpressure, frame ends and clears
    for (int cyc = 0; cyc < 400; cyc++) begin
      apply_stimulus($urandom_range(0, 9) < 7, IW'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3);
      Reset = ($urandom_range(0, 59) == 0);
      clock_cycle();
    end
    Reset = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (3) clock_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpm_word_packer.md
Name: cpm_word_packer

Overview:
Upstream feeder for the CPM 64-bit word FIFO. Accepts narrow EEG/feature samples on a valid/ready stream and packs them little-endian into DATA_WIDTH words. Drives the FIFO push/data_in/full interface directly. Supports frame-end flush with padding, synchronous clear aligned with the FIFO's Reset, and pushed-word/frame status.

Parameters:
DATA_WIDTH, 64, packed word width; must equal the downstream FIFO DATA_WIDTH.
IN_WIDTH, 8, sample width; DATA_WIDTH must be an integer multiple of IN_WIDTH.
LANES, DATA_WIDTH/IN_WIDTH, derived; samples per word (8 by default).
PAD_VALUE, 0, IN_WIDTH-bit value written to unused lanes of a flushed partial word.
WCNT_WIDTH, 16, width of the pushed-word counter.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
Reset  input  1  synchronous clear, same signal as the FIFO Reset
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid && in_ready
in_data  input  IN_WIDTH  sample
in_last  input  1  last sample of frame; qualified by in_valid
fifo_push  output  1  push strobe to FIFO
fifo_data  output  DATA_WIDTH  word to FIFO data_in
fifo_full  input  1  FIFO full flag
word_cnt  output  WCNT_WIDTH  words pushed since reset/Reset; wraps
frame_done  output  1  one-cycle pulse after the last word of a frame is pushed
busy  output  1  accumulator or hold register non-empty

Behaviour:
- Storage: accumulator acc[DATA_WIDTH], lane counter lane[clog2(LANES+1)], hold register hold[DATA_WIDTH] with hold_valid and hold_last.
- Reset values (rst_n low or Reset high at the clock edge): acc=0, lane=0, hold=0, hold_valid=0, hold_last=0, word_cnt=0, frame_done=0. Reset has priority over all other updates.
- in_ready = !(hold_valid && fifo_full) && !Reset. It is combinational.
- Accept: sample goes to lane `lane` (bits lane*IN_WIDTH upward). Lane 0 occupies the LSBs. lane increments.
- The word completes on an accept when lane==LANES-1, or when in_last=1.
  - On completion, hold is loaded with the completed word. Lanes above the current one are filled with PAD_VALUE.
  - hold_last is set to in_last. hold_valid is set to 1.
  - acc is cleared and lane returns to 0.
  - in_last on lane LANES-1 produces exactly one word with no padding.
- fifo_push = hold_valid && !fifo_full && !Reset. It is combinational. fifo_data = hold at all times.
  - fifo_push is never asserted while fifo_full=1.
- On a push edge: hold_valid clears, unless a new completion loads hold in the same edge. The same-edge load is legal because in_ready=1 whenever a push occurs. This sustains one sample per cycle.
- On a push edge: word_cnt increments, wrapping modulo 2^WCNT_WIDTH.
- frame_done = 1 for exactly the cycle following a push edge in which hold_last was 1. Otherwise 0.
- Latency: the sample that completes a word is accepted at edge N. fifo_push is high in the cycle after edge N, provided fifo_full is 0.
- Backpressure: while hold_valid && fifo_full, in_ready=0, acc/lane are frozen, and hold is stable.
- in_valid with in_ready=0: no state change. The source holds its data.
- Reset mid-word: the partial accumulator and any hold word are discarded. Nothing is pushed in the Reset cycle.
- busy = hold_valid || (lane != 0).

Test Plan:
- Feed 8 samples 0x01..0x08 back-to-back, fifo_full=0 → a single fifo_push one cycle after the 8th accept, fifo_data=0x0807060504030201, word_cnt=1, frame_done=0.
- Feed 3 samples 0xA1,0xA2,0xA3 with in_last on the 3rd, PAD_VALUE=0 → fifo_data=0x0000000000A3A2A1, one push, frame_done pulses 1 cycle later, busy=0 afterwards.
- Streaming: 24 samples with fifo_full=0 → 3 pushes at 8-cycle spacing, in_ready constantly 1, word_cnt=3.
- Hold fifo_full=1, offer 20 samples → exactly 8 accepted, then in_ready=0 and fifo_push=0. Release full → push of word 1 in the first non-full cycle, then accepts resume; all 20 samples appear in order.
- Accept 5 samples, pulse Reset, then send 8 new samples → no push of the partial word; first pushed word contains only the new 8 samples; word_cnt=1.
- Assert rst_n low while hold_valid=1 → outputs immediately reset: fifo_push=0, word_cnt=0, in_ready=1, busy=0.
